// File: rtl/gsim_matvec.sv
// Streaming 7-band matrix-vector multiplier (taps -1,6,-13,20,-13,6,-1) over N-entry frames.
// Emits full-precision M*x plus a rounded, saturated 16-bit integer copy.
module gsim_matvec #(
   parameter int N = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_en,
   input  logic [31:0] x_in,
   output logic        out_valid,
   output logic [37:0] mb_out,
   output logic [15:0] b_out,
   output logic        frame_done
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
   localparam logic [CW-1:0] FIRST_OUT = CW'(3);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [1:0]     fcnt_q, fcnt_d;
   logic [31:0]    w_q [7];
   logic [31:0]    w_d [7];
   logic [31:0]    w_sh [7];
   logic [31:0]    shift_val;
   logic           shift, emit, clear, last;

   logic signed [37:0] e [7];
   logic signed [37:0] mb_c, rnd_c;
   logic signed [21:0] r_c;
   logic [15:0]        b_c;

   logic        out_valid_q, out_valid_d;
   logic        frame_done_q, frame_done_d;
   logic [37:0] mb_q, mb_d;
   logic [15:0] b_q, b_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fcnt_d    = fcnt_q;
      shift     = 1'b0;
      shift_val = '0;
      emit      = 1'b0;
      clear     = 1'b0;
      last      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (in_en) begin
               shift     = 1'b1;
               shift_val = x_in;
               cnt_d     = CW'(1);
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_en) begin
               shift     = 1'b1;
               shift_val = x_in;
               cnt_d     = cnt_q + CW'(1);
               emit      = (cnt_q >= FIRST_OUT);
               if (cnt_q == LAST_IDX) begin
                  state_d = S_FLUSH;
                  fcnt_d  = '0;
               end
            end
         end
         S_FLUSH: begin
            // zeros enter the window; inputs are dropped
            shift  = 1'b1;
            emit   = 1'b1;
            fcnt_d = fcnt_q + 2'd1;
            if (fcnt_q == 2'd2) begin
               last    = 1'b1;
               clear   = 1'b1;
               cnt_d   = '0;
               fcnt_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output is formed from the post-shift window so row j leaves with x[j+3]'s accept.
   always_comb begin
      for (int unsigned i = 0; i < 6; i++) begin
         w_sh[i] = w_q[i+1];
      end
      w_sh[6] = shift_val;
      for (int unsigned i = 0; i < 7; i++) begin
         w_d[i] = clear ? '0 : (shift ? w_sh[i] : w_q[i]);
         e[i]   = {{6{w_sh[i][31]}}, w_sh[i]};
      end
      mb_c  = 38'sd20 * e[3] - 38'sd13 * (e[2] + e[4])
            + 38'sd6 * (e[1] + e[5]) - (e[0] + e[6]);
      rnd_c = mb_c + 38'sd32768;
      r_c   = rnd_c[37:16];
      if (r_c > 22'sd32767) begin
         b_c = 16'h7FFF;
      end else if (r_c < -22'sd32768) begin
         b_c = 16'h8000;
      end else begin
         b_c = r_c[15:0];
      end
   end

   always_comb begin
      out_valid_d  = emit;
      frame_done_d = last;
      mb_d         = emit ? mb_c : mb_q;
      b_d          = emit ? b_c : b_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         fcnt_q       <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         mb_q         <= '0;
         b_q          <= '0;
         for (int unsigned i = 0; i < 7; i++) begin
            w_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fcnt_q       <= fcnt_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         mb_q         <= mb_d;
         b_q          <= b_d;
         for (int unsigned i = 0; i < 7; i++) begin
            w_q[i] <= w_d[i];
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;
   assign mb_out     = mb_q;
   assign b_out      = b_q;

endmodule

// File: tb/tb_gsim_matvec.sv
// Bench for gsim_matvec: directed and random frames checked against a row-sum model
// of the banded matrix, including output timing, frame_done and mid-frame reset.
module tb_gsim_matvec;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_en;
   logic [31:0] x_in;
   logic        out_valid;
   logic [37:0] mb_out;
   logic [15:0] b_out;
   logic        frame_done;

   gsim_matvec #(.N(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_en      (in_en),
      .x_in       (x_in),
      .out_valid  (out_valid),
      .mb_out     (mb_out),
      .b_out      (b_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   int nerr    = 0;
   int nchecks = 0;

   logic signed [63:0] obs_mb[$], obs_b[$], obs_edge[$], obs_fd[$];
   logic signed [63:0] want_mb[$], want_b[$], want_edge[$], want_fd[$];
   int fd_stray = 0;

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         obs_mb.push_back(64'($signed(mb_out)));
         obs_b.push_back(64'($signed(b_out)));
         obs_edge.push_back(64'(edge_n));
         obs_fd.push_back(64'(frame_done));
      end else if (frame_done !== 1'b0) begin
         fd_stray++;
      end
   end

   logic [31:0] xv [N];
   int          acc [N];
   int          ones_tab [N] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
   int          imp_tab  [N] = '{0, 0, -1, 6, -13, 20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0};
   int          p0;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] want);
      nchecks++;
      assert (obs === want) else begin
         nerr++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, want);
      end
   endtask

   function automatic logic signed [63:0] tap(input int d);
      case (d)
         0:       return 64'sd20;
         1:       return -64'sd13;
         2:       return 64'sd6;
         3:       return -64'sd1;
         default: return 64'sd0;
      endcase
   endfunction

   function automatic logic signed [63:0] ref_b(input logic signed [63:0] mb);
      logic signed [63:0] r;
      r = (mb + 64'sd32768) >>> 16;
      if (r > 64'sd32767) r = 64'sd32767;
      else if (r < -64'sd32768) r = -64'sd32768;
      return r;
   endfunction

   // Drives xv as one frame, then 3 flush cycles (in_en pulsed or idle), and queues
   // the expected rows with the cycle each row must appear in.
   task automatic drive_frame(input int gapmax, input bit pulses);
      logic signed [63:0] mb;
      for (int k = 0; k < N; k++) begin
         int gap;
         gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
         repeat (gap) begin
            in_en = 1'b0;
            x_in  = $urandom;
            @(negedge clk);
         end
         in_en = 1'b1;
         x_in  = xv[k];
         @(negedge clk);
         acc[k] = edge_n;
      end
      repeat (3) begin
         in_en = pulses;
         x_in  = $urandom;
         @(negedge clk);
      end
      in_en = 1'b0;
      for (int j = 0; j < N; j++) begin
         mb = 0;
         for (int k = 0; k < N; k++) begin
            int d;
            d = (k > j) ? k - j : j - k;
            if (d <= 3) mb += tap(d) * 64'($signed(xv[k]));
         end
         want_mb.push_back(mb);
         want_b.push_back(ref_b(mb));
         want_edge.push_back(64'((j <= N - 4) ? acc[j+3] : acc[N-1] + j - (N - 4)));
         want_fd.push_back(64'(j == N - 1));
      end
   endtask

   task automatic check_outputs(input string tag);
      int budget;
      budget = 0;
      while (obs_mb.size() < want_mb.size() && budget < 300) begin
         @(negedge clk);
         budget++;
      end
      repeat (4) @(negedge clk);
      chk({tag, " count"}, 64'(obs_mb.size()), 64'(want_mb.size()));
      for (int i = 0; i < want_mb.size() && i < obs_mb.size(); i++) begin
         chk($sformatf("%s mb[%0d]", tag, i), obs_mb[i], want_mb[i]);
         chk($sformatf("%s b[%0d]", tag, i), obs_b[i], want_b[i]);
         chk($sformatf("%s cycle[%0d]", tag, i), obs_edge[i], want_edge[i]);
         chk($sformatf("%s frame_done[%0d]", tag, i), obs_fd[i], want_fd[i]);
      end
      if (want_mb.size() > 0) begin
         chk({tag, " hold mb"}, 64'($signed(mb_out)), want_mb[want_mb.size()-1]);
         chk({tag, " hold b"}, 64'($signed(b_out)), want_b[want_b.size()-1]);
      end
      chk({tag, " stray frame_done"}, 64'(fd_stray), 64'sd0);
   endtask

   task automatic clear_queues();
      obs_mb.delete();  obs_b.delete();  obs_edge.delete();  obs_fd.delete();
      want_mb.delete(); want_b.delete(); want_edge.delete(); want_fd.delete();
      fd_stray = 0;
   endtask

   task automatic check_ones_table(input string tag);
      for (int j = 0; j < N && j < obs_b.size(); j++) begin
         chk($sformatf("%s table b[%0d]", tag, j), obs_b[j], 64'(ones_tab[j]));
         chk($sformatf("%s table cycle[%0d]", tag, j), obs_edge[j] - 64'(p0) + 1, 64'(j + 4));
      end
      if (obs_mb.size() > 8) chk({tag, " interior mb"}, obs_mb[8], 64'sh40000);
   endtask

   initial begin
      reset = 1'b1;
      in_en = 1'b0;
      x_in  = '0;
      repeat (3) @(negedge clk);
      chk("reset out_valid", 64'(out_valid), 64'sd0);
      chk("reset frame_done", 64'(frame_done), 64'sd0);
      chk("reset mb_out", 64'(mb_out), 64'sd0);
      chk("reset b_out", 64'(b_out), 64'sd0);
      reset = 1'b0;
      @(negedge clk);
      clear_queues();

      for (int k = 0; k < N; k++) xv[k] = 32'h0001_0000;
      drive_frame(0, 1'b0);
      p0 = acc[0];
      check_outputs("ones");
      check_ones_table("ones");
      clear_queues();

      for (int k = 0; k < N; k++) xv[k] = '0;
      xv[5] = 32'h0001_0000;
      drive_frame(0, 1'b0);
      check_outputs("impulse");
      for (int j = 0; j < N && j < obs_b.size(); j++)
         chk($sformatf("impulse table b[%0d]", j), obs_b[j], 64'(imp_tab[j]));
      clear_queues();

      for (int k = 0; k < N; k++) xv[k] = 32'h7FFF_FFFF;
      drive_frame(0, 1'b0);
      check_outputs("sat_max");
      if (obs_b.size() > 8) chk("sat_max interior b", obs_b[8], 64'sd32767);
      clear_queues();

      for (int k = 0; k < N; k++) xv[k] = 32'h8000_0000;
      drive_frame(0, 1'b0);
      check_outputs("sat_min");
      if (obs_b.size() > 8) begin
         chk("sat_min interior mb", obs_mb[8], -64'sd8589934592);
         chk("sat_min interior b", obs_b[8], -64'sd32768);
      end
      clear_queues();

      for (int k = 0; k < N; k++) xv[k] = '0;
      xv[1]  = 32'h0000_0800;
      xv[8]  = 32'h0000_8000;
      xv[15] = 32'h0000_8001;
      drive_frame(0, 1'b0);
      check_outputs("round");
      if (obs_b.size() == N) begin
         chk("round mb[1]", obs_mb[1], 64'sh0A000);
         chk("round b[1]", obs_b[1], 64'sd1);
         chk("round mb[5]", obs_mb[5], -64'sh8000);
         chk("round b[5]", obs_b[5], 64'sd0);
         chk("round b[11]", obs_b[11], 64'sd0);
         chk("round mb[12]", obs_mb[12], -64'sh8001);
         chk("round b[12]", obs_b[12], -64'sd1);
      end
      clear_queues();

      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < N; k++)
            xv[k] = (f % 2 == 0) ? $urandom : 32'($urandom_range(1 << 21, 0)) - 32'(1 << 20);
         drive_frame(5, 1'b1);
         check_outputs($sformatf("gapped%0d", f));
         clear_queues();
      end

      for (int k = 0; k < N; k++) xv[k] = $urandom;
      drive_frame(0, 1'b1);
      for (int k = 0; k < N; k++) xv[k] = $urandom;
      drive_frame(0, 1'b0);
      check_outputs("b2b");
      clear_queues();

      for (int k = 0; k < 8; k++) begin
         in_en = 1'b1;
         x_in  = 32'h0001_0000;
         @(negedge clk);
      end
      reset = 1'b1;
      in_en = 1'b0;
      @(negedge clk);
      chk("midreset out_valid", 64'(out_valid), 64'sd0);
      chk("midreset frame_done", 64'(frame_done), 64'sd0);
      chk("midreset mb_out", 64'(mb_out), 64'sd0);
      chk("midreset b_out", 64'(b_out), 64'sd0);
      clear_queues();
      reset = 1'b0;
      @(negedge clk);
      chk("postreset out_valid", 64'(out_valid), 64'sd0);
      repeat (3) @(negedge clk);
      chk("postreset quiet", 64'(obs_mb.size()), 64'sd0);
      for (int k = 0; k < N; k++) xv[k] = 32'h0001_0000;
      drive_frame(0, 1'b0);
      p0 = acc[0];
      check_outputs("rst_ones");
      check_ones_table("rst_ones");
      clear_queues();

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule

// File: doc/gsim_matvec.md
# gsim_matvec

Streaming banded matrix-vector multiplier that forms the reverse path of the GSIM solver interface. It consumes the solver's 16-entry solution stream (`x`, signed Q16.16) and produces `M·x` for the fixed symmetric 7-band matrix with row taps −1, 6, −13, 20, −13, 6, −1, truncated at the matrix edges. It sits downstream of `GSIM` and regenerates the right-hand side `b` on-chip for self-check and residual computation.

## Interface
Parameters:
- `N`, default 16: vector length per frame; legal range N ≥ 4.

Ports:
- `clk` — in — 1 — single clock; all flops on rising edge.
- `reset` — in — 1 — synchronous, active-high; clears all state.
- `in_en` — in — 1 — `x_in` valid this cycle.
- `x_in` — in — 32 — signed Q16.16 solution element `x[k]`.
- `out_valid` — out — 1 — `mb_out`/`b_out` valid this cycle.
- `mb_out` — out — 38 — signed Q22.16 full-precision `(M·x)[j]`.
- `b_out` — out — 16 — signed integer: `mb_out` rounded and saturated.
- `frame_done` — out — 1 — one-cycle pulse coinciding with the last output, j = N−1.

## Operation
- Window: a 7-entry shift register `w[0..6]` of 32-bit signed values; `w[6]` is newest. Each accepted input shifts in at `w[6]`. The output is computed for the centre element `w[3]`:
  - `mb = 20·w3 − 13·(w2+w4) + 6·(w1+w5) − (w0+w6)`.
  - Evaluate at 38 bits, sign-extended: |Σcoef| = 60, so 6 guard bits suffice and no overflow is possible.
- Frame start: the window is all zeros after reset and after each flush. This supplies the zero left taps for j < 3.
- FSM states:
  - IDLE: waiting for a frame.
    - `in_en` = 1 → accept `x[0]`, `cnt` = 1, go to LOAD.
  - LOAD: accepting the rest of the frame.
    - Each `in_en` = 1 accepts `x[cnt]` and increments `cnt`.
    - An accept with `cnt` ≥ 3 emits output j = `cnt` − 3.
    - The accept of `x[N−1]` transitions to FLUSH.
    - `in_en` = 0 → hold the window; no output (input gaps are legal).
  - FLUSH: 3 cycles that shift zeros into the window and emit j = N−3, N−2, N−1, one per cycle.
    - `in_en` is ignored and inputs are dropped.
    - After the 3rd cycle: clear the window, `cnt` = 0, go to IDLE.
- `b_out` rounding and saturation:
  - `r = (mb + 2^15) >>> 16` (round half up, arithmetic shift).
  - Saturate `r` to [−32768, 32767].
- Outputs are registered. `mb_out`/`b_out` hold their last value when `out_valid` = 0.

## Timing
- Reset values: `out_valid` = 0, `frame_done` = 0, `mb_out` = 0, `b_out` = 0, window = 0, `cnt` = 0, state = IDLE.
- Reset mid-frame or mid-flush:
  - Partial results are discarded.
  - `out_valid` = 0 in the cycle after reset.
  - The next `in_en` is `x[0]` of a new frame.
- Latency: output j is valid the cycle after `x[j+3]` is accepted, for j ≤ N−4. Flush outputs follow on consecutive cycles.
- Back-to-back input, first accept at cycle 0: `out_valid` is high for cycles 4 .. N+3 (16 contiguous for N = 16), and `frame_done` is high at cycle N+3.
- Throughput: one element per cycle. A new frame may begin in the cycle after the last FLUSH cycle.
- Outputs always appear in order j = 0..N−1, exactly N per frame. No backpressure.

## Test plan
- All-ones (N = 16, every `x` = 0x00010000, contiguous) → `b_out` sequence = 12, −1, 5, 4×10, 5, −1, 12. Interior `mb_out` = 0x0_0004_0000. `out_valid` is high for cycles 4–19; `frame_done` is high at cycle 19 only.
- Impulse (`x[5]` = 0x00010000, others 0) → `b_out[2..8]` = −1, 6, −13, 20, −13, 6, −1; all other entries 0.
- Saturation: all `x` = 0x7FFFFFFF → interior `b_out` = 32767. All `x` = 0x80000000 → interior `mb_out` = −2^33 and `b_out` = −32768.
- Rounding: `x[j]` = 0x00000800 in rows where `mb` = 20·0x800 = 0xA000 → `b_out` = 1. `mb` = −0x8000 → `b_out` = 0. `mb` = −0x8001 → `b_out` = −1.
- Gapped input: random `in_en` gaps of 0–5 cycles, then the GSIM golden `x` vector → outputs match the reference model bit-exactly. `in_en` pulses asserted during FLUSH are dropped.
- Reset at cycle 8 of a frame, then a clean all-ones frame → no output during or after reset until the new frame's cycle 4. Result is identical to the all-ones scenario.
